router_sync_n: RTL and testbench
================================

Name: router_sync_n

Overview:
Parametrised address-latch and FIFO-control synchroniser for the router, generalising the fixed 3-port synchroniser to NUM_PORTS output channels. It sits between the router FSM/register block and the per-port output FIFOs. It latches the destination address of each packet and steers write enables to the selected FIFO. It reports full status and per-port valid. It adds two things the fixed block lacks: invalid-address detection, and per-channel soft-reset timeouts of configurable length.

Parameters:
NUM_PORTS, 3, number of output channels/FIFOs (1..8)
ADDR_W, 2, width of packet address field; must satisfy 2^ADDR_W >= NUM_PORTS
TIMEOUT, 30, consecutive unread-valid cycles before a channel is soft-reset (2..255)

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
detect_addr  input  1  FSM strobe: data_in carries header address this cycle
data_in  input  ADDR_W  destination address from header byte
write_en_reg  input  1  FSM request to write payload into selected FIFO
rd_en  input  NUM_PORTS  per-channel read enable from downstream
full  input  NUM_PORTS  per-FIFO full flags
empty  input  NUM_PORTS  per-FIFO empty flags
write_en  output  NUM_PORTS  one-hot FIFO write enable
fifo_full  output  1  full flag of currently selected FIFO
valid_out  output  NUM_PORTS  per-channel data available
soft_rst  output  NUM_PORTS  per-channel one-cycle soft-reset pulse
sel_addr  output  ADDR_W  currently latched address
addr_err  output  1  latched address is out of range (>= NUM_PORTS)

Behaviour:
- Reset (rstn=0, asynchronous): sel_addr=0, addr_valid(internal)=0, addr_err=0, all timeout counters=0, soft_rst=0. The combinational outputs then give write_en=0 and fifo_full=0. valid_out follows empty even during reset.
- Address latch, registered:
  - On a rising edge with detect_addr=1, sel_addr<=data_in.
  - If data_in < NUM_PORTS: addr_valid<=1, addr_err<=0. Otherwise addr_valid<=0, addr_err<=1.
  - Held until the next detect_addr.
- The new address takes effect the cycle after detect_addr. If detect_addr and write_en_reg are high together, write_en in that cycle uses the old sel_addr.
- write_en, combinational:
  - write_en[sel_addr] = write_en_reg & addr_valid; all other bits 0.
  - Never more than one bit high.
  - All bits 0 while addr_err=1, so the packet is dropped.
- fifo_full, combinational: full[sel_addr] when addr_valid=1, else 0. It does not gate write_en; FIFO overflow protection stays in the FIFO and the FSM.
- valid_out[i] = ~empty[i], combinational, zero latency.
- Soft-reset timeout, independent per channel i, on each rising edge:
  - stall_i = valid_out[i] & ~rd_en[i].
  - stall_i=0: counter_i<=0, soft_rst[i]<=0.
  - stall_i=1 and counter_i < TIMEOUT-1: counter_i<=counter_i+1, soft_rst[i]<=0.
  - stall_i=1 and counter_i == TIMEOUT-1: soft_rst[i]<=1, counter_i<=0.
- Consequences of the timeout rules:
  - soft_rst[i] is a single-cycle pulse, high in the cycle after the TIMEOUT-th consecutive stalled edge.
  - If the stall persists, the next pulse comes TIMEOUT cycles later.
  - A single rd_en[i]=1 cycle restarts the count.
  - The counter is ceil(log2(TIMEOUT)) bits wide and never wraps past TIMEOUT-1.
- Channels are fully independent; simultaneous timeouts on several channels pulse together.
- soft_rst does not alter sel_addr or addr_err. The FIFO is responsible for asserting empty after soft reset, which clears the stall.
- rstn dropping mid-count or mid-packet clears everything immediately, with no pulse emitted.

Test Plan:
1. Reset, then detect_addr=1, data_in=2 for one edge, then write_en_reg=1 → sel_addr=2, addr_err=0, write_en=3'b100. With full=3'b100, fifo_full=1.
2. detect_addr=1, data_in=3, NUM_PORTS=3, then write_en_reg=1 → addr_err=1, write_en=3'b000, fifo_full=0. Next detect with data_in=1 → addr_err=0, write_en=3'b010.
3. empty=3'b110, rd_en=0 held → valid_out=3'b001. soft_rst[0] pulses for exactly one cycle, 30 edges after stall start, and again 30 edges later. soft_rst[1] and soft_rst[2] stay 0.
4. Channel 0 stalled 29 edges, rd_en[0]=1 for 1 cycle, then stalled again → no pulse until 30 further stalled edges.
5. Stall channel 0 for 20 edges, then pulse rstn=0 asynchronously (mid-cycle) → soft_rst=0 and sel_addr=0 immediately. After release, a full 30 new stalled edges are needed for a pulse.
6. NUM_PORTS=4, ADDR_W=2, TIMEOUT=4: detect data_in=3 → write_en=4'b1000. Stall channel 3 → soft_rst[3] pulses every 4 cycles.

Source files
------------

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the packet destination address and steers the FIFO write enable.
// It also reports full/valid status and soft-resets any channel left unread for TIMEOUT cycles.
module router_sync_n #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = 30
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 detect_addr,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_en_reg,
  input  logic [NUM_PORTS-1:0] rd_en,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] empty,
  output logic [NUM_PORTS-1:0] write_en,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] valid_out,
  output logic [NUM_PORTS-1:0] soft_rst,
  output logic [ADDR_W-1:0]    sel_addr,
  output logic                 addr_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic                 addr_valid;
  logic [NUM_PORTS-1:0] stall;

  // An out-of-range address is still latched so software can see what arrived.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_addr   <= '0;
      addr_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else if (detect_addr) begin
      sel_addr <= data_in;
      if (int'(data_in) < NUM_PORTS) begin
        addr_valid <= 1'b1;
        addr_err   <= 1'b0;
      end else begin
        addr_valid <= 1'b0;
        addr_err   <= 1'b1;
      end
    end
  end

  always_comb begin
    write_en  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_valid && (sel_addr == ADDR_W'(i))) begin
        write_en[i] = write_en_reg;
        fifo_full   = full[i];
      end
    end
  end

  assign valid_out = ~empty;
  assign stall     = valid_out & ~rd_en;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timeout
    logic [CNT_W-1:0] cnt;

    // Counter restarts on the pulse edge, so a persistent stall repeats every TIMEOUT cycles.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt         <= '0;
        soft_rst[g] <= 1'b0;
      end else if (!stall[g]) begin
        cnt         <= '0;
        soft_rst[g] <= 1'b0;
      end else if (cnt == CNT_MAX) begin
        cnt         <= '0;
        soft_rst[g] <= 1'b1;
      end else begin
        cnt         <= cnt + 1'b1;
        soft_rst[g] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n: default 3-port instance plus a 4-port, TIMEOUT=4 instance.
module tb_router_sync_n;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic       det_a, wreg_a;
  logic [1:0] din_a, sel_a;
  logic [2:0] rd_a, full_a, empty_a, we_a, vld_a, srst_a;
  logic       ff_a, err_a;

  logic       det_b, wreg_b;
  logic [1:0] din_b, sel_b;
  logic [3:0] rd_b, full_b, empty_b, we_b, vld_b, srst_b;
  logic       ff_b, err_b;

  router_sync_n dut_a (
    .clk(clk), .rstn(rstn), .detect_addr(det_a), .data_in(din_a), .write_en_reg(wreg_a),
    .rd_en(rd_a), .full(full_a), .empty(empty_a), .write_en(we_a), .fifo_full(ff_a),
    .valid_out(vld_a), .soft_rst(srst_a), .sel_addr(sel_a), .addr_err(err_a)
  );

  router_sync_n #(.NUM_PORTS(4), .ADDR_W(2), .TIMEOUT(4)) dut_b (
    .clk(clk), .rstn(rstn), .detect_addr(det_b), .data_in(din_b), .write_en_reg(wreg_b),
    .rd_en(rd_b), .full(full_b), .empty(empty_b), .write_en(we_b), .fifo_full(ff_b),
    .valid_out(vld_b), .soft_rst(srst_b), .sel_addr(sel_b), .addr_err(err_b)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    det_a = 1'b1; din_a = 2'd2; wreg_a = 1'b1;
    rd_a = '0; full_a = 3'b111; empty_a = 3'b010;
    det_b = 1'b0; din_b = '0; wreg_b = 1'b0;
    rd_b = '0; full_b = '0; empty_b = 4'hF;

    // Reset: address logic held, write path gated, valid_out still live.
    tick(); tick();
    expect_val(0);      check("rst_sel_addr", sel_a);
    expect_val(0);      check("rst_addr_err", err_a);
    expect_val(0);      check("rst_write_en", we_a);
    expect_val(0);      check("rst_fifo_full", ff_a);
    expect_val(0);      check("rst_soft_rst", srst_a);
    expect_val(3'b101); check("rst_valid_out", vld_a);

    wreg_a = 1'b0; det_a = 1'b0; empty_a = 3'b111; full_a = '0;
    rstn = 1'b1;

    // Test 1: latch address 2, steer write, report full.
    det_a = 1'b1; din_a = 2'd2;
    tick();
    det_a = 1'b0; wreg_a = 1'b1; full_a = 3'b100;
    #1;
    expect_val(2);      check("t1_sel_addr", sel_a);
    expect_val(0);      check("t1_addr_err", err_a);
    expect_val(3'b100); check("t1_write_en", we_a);
    expect_val(1);      check("t1_fifo_full", ff_a);
    full_a = 3'b011;
    #1;
    expect_val(0);      check("t1_fifo_full_other", ff_a);

    // New address only takes effect after the detect edge.
    det_a = 1'b1; din_a = 2'd0;
    #1;
    expect_val(3'b100); check("t1_we_old_addr", we_a);
    tick();
    det_a = 1'b0;
    expect_val(3'b001); check("t1_we_new_addr", we_a);

    // Test 2: out-of-range address drops the packet, then recovers.
    det_a = 1'b1; din_a = 2'd3;
    tick();
    det_a = 1'b0; full_a = 3'b111;
    #1;
    expect_val(1);      check("t2_addr_err", err_a);
    expect_val(3);      check("t2_sel_addr", sel_a);
    expect_val(0);      check("t2_write_en", we_a);
    expect_val(0);      check("t2_fifo_full", ff_a);
    det_a = 1'b1; din_a = 2'd1;
    tick();
    det_a = 1'b0;
    #1;
    expect_val(0);      check("t2_addr_err_clr", err_a);
    expect_val(3'b010); check("t2_write_en", we_a);
    expect_val(1);      check("t2_fifo_full", ff_a);
    wreg_a = 1'b0; full_a = '0;

    // Test 3: channel 0 stalled continuously pulses every 30 edges.
    empty_a = 3'b110; rd_a = '0;
    #1;
    expect_val(3'b001); check("t3_valid_out", vld_a);
    for (int e = 1; e <= 61; e++) begin
      tick();
      expect_val((e == 30 || e == 60) ? 3'b001 : 3'b000);
      check($sformatf("t3_soft_rst_e%0d", e), srst_a);
    end
    empty_a = 3'b111;
    tick();

    // Test 4: one read cycle at count 29 restarts the count.
    empty_a = 3'b110;
    for (int e = 1; e <= 29; e++) begin
      tick();
      expect_val(0); check($sformatf("t4_pre_e%0d", e), srst_a);
    end
    rd_a = 3'b001;
    tick();
    expect_val(0); check("t4_read", srst_a);
    rd_a = '0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      expect_val((e == 30) ? 3'b001 : 3'b000);
      check($sformatf("t4_post_e%0d", e), srst_a);
    end
    empty_a = 3'b111;
    tick();

    // Test 5: asynchronous reset mid-count clears state immediately.
    empty_a = 3'b110;
    for (int e = 1; e <= 20; e++) tick();
    #2;
    rstn = 1'b0;
    #1;
    expect_val(0); check("t5_soft_rst", srst_a);
    expect_val(0); check("t5_sel_addr", sel_a);
    tick();
    rstn = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      expect_val((e == 30) ? 3'b001 : 3'b000);
      check($sformatf("t5_post_e%0d", e), srst_a);
    end
    empty_a = 3'b111;

    // Test 6: 4-port instance, TIMEOUT=4.
    det_b = 1'b1; din_b = 2'd3;
    tick();
    det_b = 1'b0; wreg_b = 1'b1; full_b = 4'b1000;
    #1;
    expect_val(4'b1000); check("t6_write_en", we_b);
    expect_val(0);       check("t6_addr_err", err_b);
    expect_val(1);       check("t6_fifo_full", ff_b);
    wreg_b = 1'b0;
    empty_b = 4'b0111; rd_b = '0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      expect_val((e % 4 == 0) ? 4'b1000 : 4'b0000);
      check($sformatf("t6_soft_rst_e%0d", e), srst_b);
    end
    empty_b = 4'hF;

    if (exp_q.size() != 0) begin
      bad++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
